// File: rtl/div_seq_param_if.sv
// Handshake/operand bundle for the sequential divider.
// The requester drives start/sgn/x/y; the divider returns q/r/ready/dz/ovf.
interface div_seq_param_if #(
  parameter int W = 8
);
  logic         start;
  logic         sgn;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic [W-1:0] q;
  logic [W-1:0] r;
  logic         ready;
  logic         dz;
  logic         ovf;

  modport master (
    output start, sgn, x, y,
    input  q, r, ready, dz, ovf
  );

  modport slave (
    input  start, sgn, x, y,
    output q, r, ready, dz, ovf
  );
endinterface

// File: rtl/div_seq_param.sv
// Parametrised multi-cycle restoring divider, one operation in flight.
// Signed operations divide magnitudes and fix signs afterwards: the quotient
// truncates toward zero and the remainder follows the dividend's sign.
// Divide-by-zero and signed overflow bypass the iteration loop and complete
// in a fixed two cycles; every other operation takes W+1 cycles.
module div_seq_param #(
  parameter int W  = 8,
  parameter int CW = $clog2(W+1)
) (
  input  logic            clk,
  input  logic            reset,
  div_seq_param_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t          state;
  state_t          state_nx;

  logic [CW-1:0]   cnt;
  logic [W-1:0]    a;        // dividend bits shift out, quotient bits shift in
  logic [W-1:0]    dm;       // divisor magnitude
  logic [W:0]      p;        // partial remainder
  logic            neg_q;
  logic            neg_r;
  logic            dz_l;
  logic            ovf_l;
  logic            fix_hold;

  logic [W-1:0]    q_r;
  logic [W-1:0]    r_r;
  logic            dz_r;
  logic            ovf_r;

  logic            ready_w;
  logic            accept;
  logic            x_neg;
  logic            y_neg;
  logic [W-1:0]    x_mag;
  logic [W-1:0]    y_mag;
  logic            y_zero;
  logic            ovf_c;
  logic            fast;
  logic            last_iter;
  logic [W+1:0]    trial;
  logic            trial_neg;
  logic [W-1:0]    q_fix;
  logic [W-1:0]    r_fix;

  // Operand decode and single-iteration arithmetic
  always_comb begin
    ready_w   = (state == IDLE) || (state == DONE);
    accept    = ready_w && bus.start;
    x_neg     = bus.sgn && bus.x[W-1];
    y_neg     = bus.sgn && bus.y[W-1];
    // Negating the most negative value yields 2^(W-1), which is the correct
    // unsigned magnitude, so no special case is needed here.
    x_mag     = x_neg ? ('0 - bus.x) : bus.x;
    y_mag     = y_neg ? ('0 - bus.y) : bus.y;
    y_zero    = (bus.y == '0);
    ovf_c     = bus.sgn && (bus.x == {1'b1, {(W-1){1'b0}}}) && (bus.y == '1);
    fast      = y_zero || ovf_c;
    last_iter = (cnt == CW'(W-1));
    // p < dm <= 2^W keeps the shifted value below 2^(W+1), so a W+2 bit
    // difference always has a trustworthy sign bit.
    trial     = {p, a[W-1]} - {2'b00, dm};
    trial_neg = trial[W+1];
    q_fix     = neg_q ? ('0 - a) : a;
    r_fix     = neg_r ? ('0 - p[W-1:0]) : p[W-1:0];
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: begin
        if (accept) state_nx = fast ? FIX : RUN;
      end
      RUN: begin
        if (last_iter) state_nx = FIX;
      end
      FIX: begin
        if (!fix_hold) state_nx = DONE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Operand latch, shift/subtract iterations and result load
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt      <= '0;
      a        <= '0;
      dm       <= '0;
      p        <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      dz_l     <= 1'b0;
      ovf_l    <= 1'b0;
      fix_hold <= 1'b0;
      q_r      <= '0;
      r_r      <= '0;
      dz_r     <= 1'b0;
      ovf_r    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            cnt      <= '0;
            dm       <= y_mag;
            dz_l     <= y_zero;
            ovf_l    <= ovf_c && !y_zero;
            dz_r     <= 1'b0;
            ovf_r    <= 1'b0;
            // Flagged operations get their final q/r staged straight into
            // the working registers, with sign fix-up disabled, and spend one
            // extra cycle in FIX so their latency is always two cycles.
            fix_hold <= fast;
            if (y_zero) begin
              a     <= '1;
              p     <= {1'b0, bus.x};
              neg_q <= 1'b0;
              neg_r <= 1'b0;
            end else if (ovf_c) begin
              a     <= bus.x;
              p     <= '0;
              neg_q <= 1'b0;
              neg_r <= 1'b0;
            end else begin
              a     <= x_mag;
              p     <= '0;
              neg_q <= x_neg ^ y_neg;
              neg_r <= x_neg;
            end
          end
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          if (trial_neg) begin
            p <= {p[W-1:0], a[W-1]};
            a <= {a[W-2:0], 1'b0};
          end else begin
            p <= trial[W:0];
            a <= {a[W-2:0], 1'b1};
          end
        end
        FIX: begin
          if (fix_hold) begin
            fix_hold <= 1'b0;
          end else begin
            q_r   <= q_fix;
            r_r   <= r_fix;
            dz_r  <= dz_l;
            ovf_r <= ovf_l;
          end
        end
        default: begin
          cnt <= '0;
        end
      endcase
    end
  end

  assign bus.q     = q_r;
  assign bus.r     = r_r;
  assign bus.dz    = dz_r;
  assign bus.ovf   = ovf_r;
  assign bus.ready = ready_w;

endmodule
